// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game FSM (slave side) and the datapath/board (master side).
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       nivel;
  logic       tem_jogada;
  logic       acertouJogada;
  logic       fimS;
  logic       timeout;

  logic       zeraT;
  logic       zeraS;
  logic       contaS;
  logic       zeraR;
  logic       registraR;
  logic       zeraA;
  logic       registraA;
  logic       zeraL;
  logic       registraL;
  logic       zeraN;
  logic       registraN;

  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, nivel, tem_jogada, acertouJogada, fimS, timeout,
    output zeraT, zeraS, contaS, zeraR, registraR, zeraA, registraA,
           zeraL, registraL, zeraN, registraN,
           pronto, ganhou, perdeu, db_timeout, db_estado
  );

  modport master (
    output iniciar, nivel, tem_jogada, acertouJogada, fimS, timeout,
    input  zeraT, zeraS, contaS, zeraR, registraR, zeraA, registraA,
           zeraL, registraL, zeraN, registraN,
           pronto, ganhou, perdeu, db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game: sequences LED display, play capture,
// comparison and the three end-of-game outcomes.
module unidade_controle_jogo #(
  parameter logic NIVEL_TIMEOUT = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_jogo_if.slave  bus
);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARACAO    = 4'd1,
    MOSTRA_LED    = 4'd2,
    ESPERA_JOGADA = 4'd3,
    REGISTRA      = 4'd4,
    COMPARACAO    = 4'd5,
    PROXIMA       = 4'd6,
    FIM_ACERTO    = 4'd7,
    FIM_ERRO      = 4'd8,
    FIM_TIMEOUT   = 4'd9
  } estado_t;

  estado_t estado_q, estado_d;
  logic    nivel_q, nivel_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      nivel_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      nivel_q  <= nivel_d;
    end
  end

  // Outputs depend on estado_q only; inputs affect nothing but estado_d/nivel_d.
  always_comb begin
    estado_d       = estado_q;
    nivel_d        = nivel_q;
    bus.zeraT      = 1'b0;
    bus.zeraS      = 1'b0;
    bus.contaS     = 1'b0;
    bus.zeraR      = 1'b0;
    bus.registraR  = 1'b0;
    bus.zeraA      = 1'b0;
    bus.registraA  = 1'b0;
    bus.zeraL      = 1'b0;
    bus.registraL  = 1'b0;
    bus.zeraN      = 1'b0;
    bus.registraN  = 1'b0;
    bus.pronto     = 1'b0;
    bus.ganhou     = 1'b0;
    bus.perdeu     = 1'b0;
    bus.db_timeout = 1'b0;

    case (estado_q)
      INICIAL: begin
        bus.zeraN = 1'b1;
        if (bus.iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        bus.zeraS     = 1'b1;
        bus.zeraR     = 1'b1;
        bus.zeraA     = 1'b1;
        bus.zeraL     = 1'b1;
        bus.zeraT     = 1'b1;
        bus.registraN = 1'b1;
        nivel_d       = bus.nivel;
        estado_d      = MOSTRA_LED;
      end
      MOSTRA_LED: begin
        bus.registraL = 1'b1;
        bus.zeraT     = 1'b1;
        bus.zeraR     = 1'b1;
        estado_d      = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        // A play arriving together with a timeout still counts.
        if (bus.tem_jogada)
          estado_d = REGISTRA;
        else if (bus.timeout && (nivel_q == NIVEL_TIMEOUT))
          estado_d = FIM_TIMEOUT;
      end
      REGISTRA: begin
        bus.registraR = 1'b1;
        estado_d      = COMPARACAO;
      end
      COMPARACAO: begin
        if (!bus.acertouJogada)
          estado_d = FIM_ERRO;
        else if (bus.fimS)
          estado_d = FIM_ACERTO;
        else
          estado_d = PROXIMA;
      end
      PROXIMA: begin
        bus.contaS    = 1'b1;
        bus.registraA = 1'b1;
        estado_d      = MOSTRA_LED;
      end
      FIM_ACERTO: begin
        bus.pronto = 1'b1;
        bus.ganhou = 1'b1;
        if (bus.iniciar) estado_d = PREPARACAO;
      end
      FIM_ERRO: begin
        bus.pronto = 1'b1;
        bus.perdeu = 1'b1;
        if (bus.iniciar) estado_d = PREPARACAO;
      end
      FIM_TIMEOUT: begin
        bus.pronto     = 1'b1;
        bus.perdeu     = 1'b1;
        bus.db_timeout = 1'b1;
        if (bus.iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo: table vectors plus game-level sequences,
// each expected state/output word queued on drive and checked after the clock edge.
module tb_unidade_controle_jogo;

  logic clock;
  logic reset;

  unidade_controle_jogo_if bus ();

  unidade_controle_jogo #(.NIVEL_TIMEOUT(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Bit positions in the packed output word
  localparam int ZT = 14, ZS = 13, CS = 12, ZR = 11, RR = 10, ZA = 9, RA = 8;
  localparam int ZL = 7, RL = 6, ZN = 5, RN = 4, PR = 3, GA = 2, PE = 1, DT = 0;

  typedef struct {
    logic       r, i, n, t, a, f, o;
    logic [3:0] st;
    string      nm;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] outs;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_conta = 0;
  int   n_rega = 0;

  function automatic logic [14:0] outs_for(input logic [3:0] st);
    logic [14:0] o;
    o = '0;
    case (st)
      4'd0: o[ZN] = 1'b1;
      4'd1: begin o[ZS] = 1'b1; o[ZR] = 1'b1; o[ZA] = 1'b1; o[ZL] = 1'b1; o[ZT] = 1'b1; o[RN] = 1'b1; end
      4'd2: begin o[RL] = 1'b1; o[ZT] = 1'b1; o[ZR] = 1'b1; end
      4'd4: o[RR] = 1'b1;
      4'd6: begin o[CS] = 1'b1; o[RA] = 1'b1; end
      4'd7: begin o[PR] = 1'b1; o[GA] = 1'b1; end
      4'd8: begin o[PR] = 1'b1; o[PE] = 1'b1; end
      4'd9: begin o[PR] = 1'b1; o[PE] = 1'b1; o[DT] = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [14:0] actual_outs();
    return {bus.zeraT, bus.zeraS, bus.contaS, bus.zeraR, bus.registraR, bus.zeraA,
            bus.registraA, bus.zeraL, bus.registraL, bus.zeraN, bus.registraN,
            bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};
  endfunction

  task automatic step(input logic r, i, n, t, a, f, o, input logic [3:0] es, input string nm);
    exp_t        e;
    logic [14:0] act;
    reset             = r;
    bus.iniciar       = i;
    bus.nivel         = n;
    bus.tem_jogada    = t;
    bus.acertouJogada = a;
    bus.fimS          = f;
    bus.timeout       = o;
    e.st   = es;
    e.outs = outs_for(es);
    e.nm   = nm;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e   = sb.pop_front();
    act = actual_outs();
    vectors++;
    if (bus.db_estado !== e.st || act !== e.outs) begin
      miscompares++;
      $display("FAIL %s: got db_estado=%0d outs=%b, expected db_estado=%0d outs=%b",
               e.nm, bus.db_estado, act, e.st, e.outs);
    end
    if (bus.contaS === 1'b1)    n_conta++;
    if (bus.registraA === 1'b1) n_rega++;
  endtask

  task automatic check_count(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d pulses, expected %0d", nm, got, want);
    end
  endtask

  // From inicial or a fim state through preparacao/mostra_led into espera_jogada
  task automatic start_game(input logic niv, input string nm);
    step(0, 1, niv, 0, 0, 0, 0, 4'd1, {nm, "_prep"});
    step(0, 0, niv, 0, 0, 0, 0, 4'd2, {nm, "_mostra"});
    step(0, 0, niv, 0, 0, 0, 0, 4'd3, {nm, "_espera"});
  endtask

  task automatic play(input logic ac, input logic fs, input logic [3:0] dest, input string nm);
    step(0, 0, 0, 1, 0, 0, 0, 4'd4, {nm, "_registra"});
    step(0, 0, 0, 0, 0, 0, 0, 4'd5, {nm, "_comparacao"});
    step(0, 0, 0, 0, ac, fs, 0, dest, {nm, "_decide"});
    if (dest == 4'd6) begin
      step(0, 0, 0, 0, 0, 0, 0, 4'd2, {nm, "_mostra"});
      step(0, 0, 0, 0, 0, 0, 0, 4'd3, {nm, "_espera"});
    end
  endtask

  vec_t tbl[20];

  initial begin
    //            r  i  n  t  a  f  o  st
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 4'd0, "reset"};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 4'd0, "idle_inicial"};
    tbl[2]  = '{0, 0, 0, 1, 1, 1, 1, 4'd0, "tj_ignored_inicial"};
    tbl[3]  = '{0, 1, 1, 0, 0, 0, 0, 4'd1, "iniciar"};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 4'd2, "prep_to_mostra"};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 4'd3, "tj_ignored_mostra"};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 4'd3, "wait_espera"};
    tbl[7]  = '{0, 0, 0, 1, 0, 0, 0, 4'd4, "play_registra"};
    tbl[8]  = '{0, 0, 0, 1, 1, 0, 0, 4'd5, "registra_to_comp"};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 4'd6, "comp_to_proxima"};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 4'd2, "proxima_to_mostra"};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 4'd3, "back_to_espera"};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 4'd4, "play2_registra"};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 4'd5, "play2_comp"};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 4'd8, "wrong_to_erro"};
    tbl[15] = '{0, 0, 0, 1, 0, 0, 0, 4'd8, "hold_erro"};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 0, 4'd1, "restart_from_erro"};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 4'd2, "restart_mostra"};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 4'd3, "restart_espera"};
    tbl[19] = '{1, 1, 0, 1, 0, 0, 0, 4'd0, "reset_mid_game"};

    for (int k = 0; k < 20; k++)
      step(tbl[k].r, tbl[k].i, tbl[k].n, tbl[k].t, tbl[k].a, tbl[k].f, tbl[k].o,
           tbl[k].st, tbl[k].nm);

    // Full win: 16 correct plays, last one at the final address
    start_game(1'b0, "win");
    n_conta = 0;
    for (int k = 0; k < 15; k++) play(1'b1, 1'b0, 4'd6, "win_play");
    play(1'b1, 1'b1, 4'd7, "win_last");
    check_count("win_contaS", n_conta, 15);
    step(0, 0, 0, 1, 1, 1, 1, 4'd7, "hold_acerto");

    // Loss on the third play
    start_game(1'b0, "loss");
    n_rega = 0;
    play(1'b1, 1'b0, 4'd6, "loss_p1");
    play(1'b1, 1'b0, 4'd6, "loss_p2");
    play(1'b0, 1'b0, 4'd8, "loss_p3");
    check_count("loss_registraA", n_rega, 2);

    // Timeout enforced at nivel=1
    start_game(1'b1, "to");
    step(0, 0, 0, 0, 0, 0, 1, 4'd9, "timeout_fim");
    step(0, 0, 0, 0, 0, 0, 1, 4'd9, "hold_timeout");

    // Play wins over a simultaneous timeout
    start_game(1'b1, "simul");
    step(0, 0, 0, 1, 0, 0, 1, 4'd4, "simul_play_wins");
    step(0, 0, 0, 0, 0, 0, 1, 4'd5, "simul_comp");
    step(0, 0, 0, 0, 1, 0, 1, 4'd6, "simul_proxima");
    step(0, 0, 0, 0, 0, 0, 1, 4'd2, "simul_mostra");
    step(0, 0, 0, 0, 0, 0, 1, 4'd3, "simul_espera");

    // Timeout ignored at nivel=0
    step(1, 0, 0, 0, 0, 0, 0, 4'd0, "reset_before_nivel0");
    start_game(1'b0, "n0");
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0, 0, 0, 1, 4'd3, "n0_timeout_ignored");
    play(1'b1, 1'b0, 4'd6, "n0_play");

    // Reset while waiting for a play
    step(1, 0, 0, 1, 1, 0, 1, 4'd0, "reset_in_espera");
    step(0, 0, 0, 1, 0, 0, 1, 4'd0, "after_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 The block SHALL have one clock `clock`; `reset` SHALL be synchronous and active-high.
REQ-002 Parameter `NIVEL_TIMEOUT`, default 1'b1: the latched `nivel` value for which a timeout ends the game.
REQ-003 `clock`  in  1  system clock; all state changes on its rising edge.
REQ-004 `reset`  in  1  synchronous, active-high; forces state `inicial`.
REQ-005 `iniciar`  in  1  start or restart request, level-sampled.
REQ-006 `nivel`  in  1  difficulty selector, captured at game start.
REQ-007 `tem_jogada`  in  1  one-cycle pulse from the datapath button edge detector.
REQ-008 `acertouJogada`  in  1  registered play matches the expected LED.
REQ-009 `fimS`  in  1  sequence counter is at its last address.
REQ-010 `timeout`  in  1  registered timeout flag from the datapath.
REQ-011 Outputs `zeraT`, `zeraS`, `contaS`, `zeraR`, `registraR`, `zeraA`, `registraA`, `zeraL`, `registraL`, `zeraN`, `registraN`  out  1 each  datapath controls with the same names.
REQ-012 `pronto`, `ganhou`, `perdeu`, `db_timeout`  out  1 each  game status.
REQ-013 `db_estado`  out  4  current state code, for the HEX4 display.

Function
REQ-014 The block SHALL be a Moore FSM: every output decoded from the state register only, with no input-to-output combinational path.
REQ-015 State codes: inicial=0, preparacao=1, mostra_led=2, espera_jogada=3, registra=4, comparacao=5, proxima=6, fim_acerto=7, fim_erro=8, fim_timeout=9; codes 10-15 unused.
REQ-016 In `inicial`: assert `zeraN`. Go to `preparacao` if `iniciar`=1, else stay.
REQ-017 In `preparacao`: assert `zeraS`, `zeraR`, `zeraA`, `zeraL`, `zeraT` and `registraN`; latch `nivel` into internal `nivel_reg`. Go unconditionally to `mostra_led`.
REQ-018 In `mostra_led`: assert `registraL`, `zeraT`, `zeraR`. Go unconditionally to `espera_jogada`.
REQ-019 In `espera_jogada`, priority order:
  - `tem_jogada`=1 -> `registra`.
  - else `timeout`=1 and `nivel_reg`==`NIVEL_TIMEOUT` -> `fim_timeout`.
  - else stay.
REQ-020 When `tem_jogada` and an enforced `timeout` occur in the same cycle, the play SHALL win (go to `registra`).
REQ-021 When `nivel_reg`!=`NIVEL_TIMEOUT`, `timeout` SHALL be ignored and the FSM waits indefinitely.
REQ-022 In `registra`: assert `registraR`. Go unconditionally to `comparacao`.
REQ-023 In `comparacao`, no control outputs:
  - `acertouJogada`=0 -> `fim_erro`.
  - `acertouJogada`=1 and `fimS`=1 -> `fim_acerto`.
  - `acertouJogada`=1 and `fimS`=0 -> `proxima`.
REQ-024 In `proxima`: assert `contaS` and `registraA` for exactly one cycle. Go to `mostra_led`.
REQ-025 Per-play latency SHALL be fixed: from the cycle `tem_jogada` is seen to re-entry of `mostra_led` is 3 clocks (registra, comparacao, proxima).
REQ-026 `fim_acerto`: `pronto`=1, `ganhou`=1.
REQ-027 `fim_erro`: `pronto`=1, `perdeu`=1.
REQ-028 `fim_timeout`: `pronto`=1, `perdeu`=1, `db_timeout`=1.
REQ-029 In all three fim states: `iniciar`=1 -> `preparacao`, else hold. Datapath registers keep their values while holding.
REQ-030 `tem_jogada` pulses in any state other than `espera_jogada` SHALL be ignored.
REQ-031 An unused state code SHALL go to `inicial` on the next clock, with all outputs 0.
REQ-032 Any zera*/registra* pair for the same register SHALL never be asserted in the same cycle.
REQ-033 `db_estado` SHALL equal the current state code in every cycle.

Reset
REQ-034 `reset`=1 at a clock edge SHALL force `inicial` and clear `nivel_reg`, regardless of current state, including mid-game; it has priority over all inputs.
REQ-035 After reset, all outputs SHALL be 0 except `zeraN`=1, and `db_estado`=0.

Verification
REQ-036 Reset asserted during `espera_jogada` -> next cycle `db_estado`=0, `zeraN`=1, all other outputs 0.
REQ-037 `iniciar` pulse, then 16 correct plays with `fimS`=1 on the 16th -> 15 `contaS` pulses, then `fim_acerto` with `ganhou`=1 and `pronto`=1.
REQ-038 Third play wrong (`acertouJogada`=0) -> `fim_erro`, `perdeu`=1; exactly 2 `registraA` pulses seen.
REQ-039 `nivel`=1 at start, `timeout`=1 in `espera_jogada` -> `db_estado`=9, `db_timeout`=1.
REQ-040 `nivel`=0 at start, `timeout` held 100 cycles -> FSM stays in state 3; a later correct play still advances.
REQ-041 `tem_jogada` and `timeout` in the same cycle with `nivel`=1 -> `registra` (code 4); from `fim_erro`, `iniciar` -> `preparacao` with `zeraS`=1.
